// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    // Rounded clk cycles per bit.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead output; full/empty derive from the count.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [UART_DATA_BITS-1:0]     wr_data,
    input  logic                          rd_en,
    output logic [UART_DATA_BITS-1:0]     q,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic                      w_wr;
    logic                      w_rd;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == CW'(0));
    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;
    assign q     = r_mem[r_rd_ptr];
    assign count = r_count;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// Buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1 frames.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      din_vld,
    output logic                      rdy,
    output logic                      tx,
    output logic                      busy,
    output logic                      ovf
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int DIV_W    = $clog2(BAUD_DIV);
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int BW       = $clog2(UART_DATA_BITS);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = ST_PARITY;
`endif

    logic [2:0]                r_state;
    logic [DIV_W-1:0]          r_div;
    logic [BW-1:0]             r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;
    logic                      r_ovf;
`ifdef UART_TX_PARITY_EN
    logic                      r_par;
`endif

    logic [UART_DATA_BITS-1:0] w_q;
    logic [CW-1:0]             w_count;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_wr;
    logic                      w_last;
    logic                      w_pop;

    // The full check uses the pre-edge count, so a same-cycle pop never frees room for a write.
    assign w_wr   = din_vld && !w_full;
    assign w_last = (r_div == DIV_W'(BAUD_DIV - 1));
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last));

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr),
        .wr_data (din),
        .rd_en   (w_pop),
        .q       (w_q),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign rdy  = (w_count <= CW'(DEPTH - 2));
    assign busy = (r_state != S_IDLE) || (w_count != CW'(0));
    assign tx   = r_tx;
    assign ovf  = r_ovf;

    // Frame sequencer; tx is registered and updated one bit ahead on each transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_q;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_par   <= even_parity(w_q);
`endif
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_div   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_div   <= '0;
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + BW'(1);
                        if (r_bit == BW'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_last) begin
                        r_div   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_last) begin
                        r_div <= '0;
                        if (w_pop) begin
                            r_shift <= w_q;
                            r_bit   <= '0;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
`ifdef UART_TX_PARITY_EN
                            r_par   <= even_parity(w_q);
`endif
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_div   <= '0;
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (din_vld && w_full) begin
            r_ovf <= 1'b1;
        end else begin
            r_ovf <= r_ovf;
        end
    end

endmodule
